// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - operand sequencer driving register-file reads, ALU and write-back
// Four-state FSM: accept instruction, read operands, execute, write back.
module reg_access_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [2:0]            instr_op,
  input  logic [ADDR_WIDTH-1:0] instr_rd,
  input  logic [ADDR_WIDTH-1:0] instr_rs1,
  input  logic [ADDR_WIDTH-1:0] instr_rs2,
  input  logic [DATA_WIDTH-1:0] instr_imm,
  output logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  reg_wr_en,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  flag_zero,
  output logic                  flag_carry
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  state_t state, state_next;

  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0] imm_q, op_a, op_b;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q, carry_q;

  logic [DATA_WIDTH:0]   alu_wide;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_carry;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    reg_wr_en   = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = READ;
      end
      READ:  state_next = EXEC;
      EXEC:  state_next = WRITE;
      WRITE: begin
        reg_wr_en  = (op_q != OP_CMP);
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The carry/borrow falls out of the extra top bit of a zero-extended add or subtract.
  always_comb begin
    alu_wide  = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_wide  = {1'b0, op_a} + {1'b0, op_b};
        alu_res   = alu_wide[DATA_WIDTH-1:0];
        alu_carry = alu_wide[DATA_WIDTH];
      end
      OP_SUB, OP_CMP: begin
        alu_wide  = {1'b0, op_a} - {1'b0, op_b};
        alu_res   = alu_wide[DATA_WIDTH-1:0];
        alu_carry = alu_wide[DATA_WIDTH];
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_MOV:  alu_res = op_a;
      OP_LDI:  alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
            imm_q <= instr_imm;
          end
        end
        READ: begin
          op_a <= rs1_data;
          op_b <= rs2_data;
        end
        EXEC: begin
          result_q <= alu_res;
          zero_q   <= (alu_res == '0);
          carry_q  <= alu_carry;
        end
        default: ;
      endcase
    end
  end

  assign rs1_addr   = rs1_q;
  assign rs2_addr   = rs2_q;
  assign wr_addr    = rd_q;
  assign wr_data    = result_q;
  assign result     = result_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb/tb_reg_access_ctrl.sv - self-checking bench for reg_access_ctrl
// Holds a behavioural register file for the DUT and a separate reference model of it.
module tb_reg_access_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_rd, instr_rs1, instr_rs2;
  logic [7:0] instr_imm;
  logic [1:0] rs1_addr, rs2_addr, wr_addr;
  logic [7:0] rs1_data, rs2_data, wr_data, result;
  logic       reg_wr_en, done, flag_zero, flag_carry;

  int checks = 0;
  int errors = 0;

  logic [7:0] rf [4];
  logic       rf_init;
  int         mregs [4];

  always #5 clk = ~clk;

  reg_access_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .reg_wr_en(reg_wr_en),
    .done(done), .result(result), .flag_zero(flag_zero), .flag_carry(flag_carry)
  );

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else if (reg_wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference ALU from the opcode rules, using plain integer arithmetic.
  task automatic ref_exec(input int op, input int a, input int b, input int imm,
                          output int res, output int z, output int c);
    int s;
    res = 0; c = 0;
    case (op)
      0: begin s = a + b; res = s % 256; c = (s > 255) ? 1 : 0; end
      1, 7: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = a;
      6: res = imm;
      default: res = 0;
    endcase
    z = (res == 0) ? 1 : 0;
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge after retirement.
  task automatic run_instr(input string tag, input int op, input int rd, input int rs1,
                           input int rs2, input int imm, input int exp_res,
                           input int exp_z, input int exp_c, input bit keep_valid);
    int exp_we;
    exp_we = (op == 7) ? 0 : 1;
    check({tag, ".ready_idle"}, instr_ready, 1);
    instr_op = op[2:0]; instr_rd = rd[1:0]; instr_rs1 = rs1[1:0];
    instr_rs2 = rs2[1:0]; instr_imm = imm[7:0]; instr_valid = 1'b1;
    @(posedge clk); #1;
    if (!keep_valid) instr_valid = 1'b0;
    @(negedge clk);
    check({tag, ".read_ready"}, instr_ready, 0);
    check({tag, ".read_we"}, reg_wr_en, 0);
    check({tag, ".read_done"}, done, 0);
    check({tag, ".rs1_addr"}, rs1_addr, rs1);
    check({tag, ".rs2_addr"}, rs2_addr, rs2);
    @(negedge clk);
    check({tag, ".exec_we"}, reg_wr_en, 0);
    check({tag, ".exec_done"}, done, 0);
    @(negedge clk);
    check({tag, ".wb_we"}, reg_wr_en, exp_we);
    check({tag, ".wb_done"}, done, 1);
    check({tag, ".wb_ready"}, instr_ready, 0);
    if (exp_we != 0) check({tag, ".wr_addr"}, wr_addr, rd);
    check({tag, ".wr_data"}, wr_data, exp_res);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".flag_zero"}, flag_zero, exp_z);
    check({tag, ".flag_carry"}, flag_carry, exp_c);
    if (exp_we != 0) mregs[rd] = exp_res;
    @(negedge clk);
    check({tag, ".post_done"}, done, 0);
    check({tag, ".post_we"}, reg_wr_en, 0);
    check({tag, ".post_ready"}, instr_ready, 1);
    check({tag, ".rf_rd"}, rf[rd], mregs[rd]);
  endtask

  typedef struct {
    int op; int rd; int rs1; int rs2; int imm;
    int exp_res; int exp_z; int exp_c; bit keep;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int op, rd, rs1, rs2, imm, res, z, c;
    reset = 1'b1; rf_init = 1'b1; instr_valid = 1'b0;
    instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0;
    for (int i = 0; i < 4; i++) mregs[i] = 0;

    vecs[0] = '{op: 6, rd: 1, rs1: 0, rs2: 0, imm: 'h3C, exp_res: 'h3C, exp_z: 0, exp_c: 0, keep: 0};
    vecs[1] = '{op: 6, rd: 2, rs1: 0, rs2: 0, imm: 'hC4, exp_res: 'hC4, exp_z: 0, exp_c: 0, keep: 0};
    vecs[2] = '{op: 0, rd: 3, rs1: 1, rs2: 2, imm: 0, exp_res: 'h00, exp_z: 1, exp_c: 1, keep: 1};
    vecs[3] = '{op: 1, rd: 0, rs1: 1, rs2: 2, imm: 0, exp_res: 'h78, exp_z: 0, exp_c: 1, keep: 0};
    vecs[4] = '{op: 7, rd: 2, rs1: 1, rs2: 1, imm: 0, exp_res: 'h00, exp_z: 1, exp_c: 0, keep: 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready", instr_ready, 1);
    check("rst.we", reg_wr_en, 0);
    check("rst.done", done, 0);
    check("rst.result", result, 0);
    check("rst.zero", flag_zero, 0);
    check("rst.carry", flag_carry, 0);
    reset = 1'b0; rf_init = 1'b0;
    @(negedge clk);

    // ADD holds instr_valid into SUB, so SUB is only taken when the DUT is idle again.
    for (int i = 0; i < 5; i++)
      run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                vecs[i].imm, vecs[i].exp_res, vecs[i].exp_z, vecs[i].exp_c, vecs[i].keep);
    check("rf.r0", rf[0], 'h78);
    check("rf.r1", rf[1], 'h3C);
    check("rf.r2", rf[2], 'hC4);
    check("rf.r3", rf[3], 'h00);

    // Reset while the LDI is in EXEC aborts it.
    instr_op = 3'd6; instr_rd = 2'd0; instr_imm = 8'hFF; instr_valid = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.result", result, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("abort.we%0d", i), reg_wr_en, 0);
      check($sformatf("abort.done%0d", i), done, 0);
      check($sformatf("abort.ready%0d", i), instr_ready, 1);
    end
    check("abort.r0", rf[0], 'h78);

    // Accept coinciding with reset is dropped.
    instr_op = 3'd6; instr_rd = 2'd3; instr_imm = 8'h55; instr_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1; instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("drop.we%0d", i), reg_wr_en, 0);
      check($sformatf("drop.done%0d", i), done, 0);
    end
    check("drop.r3", rf[3], 'h00);
    for (int i = 0; i < 4; i++) mregs[i] = rf[i] === 8'h00 ? mregs[i] : mregs[i];

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 7); rd = $urandom_range(0, 3);
      rs1 = $urandom_range(0, 3); rs2 = $urandom_range(0, 3); imm = $urandom_range(0, 255);
      ref_exec(op, mregs[rs1], mregs[rs2], imm, res, z, c);
      run_instr($sformatf("rnd%0d", n), op, rd, rs1, rs2, imm, res, z, c, $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 4; i++) check($sformatf("final.r%0d", i), rf[i], mregs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
